bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary decoder. It is the inverse of the binary-to-BCD converter in the meter datapath.
- Converts a packed multi-digit BCD word, e.g. a keypad-entered gate time or a display readback value, into an unsigned binary value.
- Uses iterative reverse double-dabble: one shift-and-correct step per clock.
- Start/busy/done handshake, so it can sit between a BCD source and the period/frequency control logic.

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd_in; digit 0 is in bits [3:0].
- BIN_W, 14, binary result width; must satisfy 10^DIGITS-1 < 2^BIN_W.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only while idle.
- bcd_in  input  4*DIGITS  packed BCD operand; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse, result/err valid.
- bin_out  output  BIN_W  binary result; held until next done.
- err  output  1  invalid-digit flag; qualified by done, held with bin_out.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, bin_out=0, err=0, shift register and iteration counter cleared.
- State IDLE:
  - busy=0.
  - On a rising edge with start=1: capture bcd_in into the upper 4*DIGITS bits of a (4*DIGITS+BIN_W)-bit shift register.
  - On that same edge: clear the lower BIN_W bits, counter=0, state->CONV.
  - start=0: remain IDLE.
- State CONV:
  - busy=1.
  - Each edge performs one iteration: shift the whole register right by 1 (zero in at MSB), then for every BCD nibble, if nibble>=8 subtract 3. The correction uses the post-shift values, all nibbles in parallel in the same cycle.
  - Counter increments each iteration.
  - On the edge performing iteration BIN_W: bin_out<=low BIN_W bits of the corrected register, err<=0, done<=1, state->IDLE.
- Latency:
  - Start accepted at edge 0.
  - done is high in the cycle following edge BIN_W (14 cycles at default).
  - done is high for exactly one cycle.
- Handshake:
  - start while busy=1 is ignored. No queuing, no effect on the conversion in flight.
  - start high in the cycle where done=1 is accepted (state is IDLE), giving back-to-back conversions every BIN_W+1... cycles min.
  - bin_out/err change only on a done edge or reset.
  - busy and done are never high in the same cycle.
- Arithmetic:
  - Unsigned only. Result is exact for any valid BCD input.
  - Corrections are 4-bit subtractions with no borrow between nibbles; nibble>=8 guarantees no underflow.
- Reset mid-CONV: abort immediately, all outputs to reset values, no done pulse.
- Counter width: $clog2(BIN_W+1) bits; no wrap occurs within a conversion.

Optional Feature:
- Macro BCD_DIGIT_CHECK_EN.
- Defined:
  - On the accepting edge, any bcd_in nibble >9 skips conversion.
  - That edge sets bin_out<=0, err<=1, done<=1, state stays IDLE, busy never asserts.
  - done is visible 1 cycle after the start edge.
  - A valid input clears err at its done.
- Undefined:
  - No check logic; err is tied 0.
  - Invalid nibbles run through the normal BIN_W-cycle conversion and produce whatever the algorithm yields (deterministic, unspecified value).

Test Plan:
- Reset, then bcd_in=16'h1234, start 1 cycle -> busy for 14 cycles, then done pulse; bin_out=14'd1234 (0x04D2), err=0.
- bcd_in=16'h9999 -> bin_out=14'h270F at done. bcd_in=16'h0000 -> bin_out=0, done still after 14 cycles.
- start held high continuously with bcd_in alternating 0x0001 and 0x0100 -> done pulses every 15 cycles; results 1 and 100. Mid-conversion bcd_in changes have no effect on the in-flight result.
- With BCD_DIGIT_CHECK_EN, bcd_in=16'h12A4 -> done and err high 1 cycle after start; bin_out=0; busy stays 0. Next valid 0x0042 -> bin_out=42, err=0.
- Start 0x5678, assert rst_n=0 at cycle 7 of CONV -> busy, done, bin_out and err go 0 asynchronously, no done pulse. After release, 0x0007 converts to 7 normally.
- Random valid BCD (>=1000 vectors) checked against a reference model -> bin_out equals decimal value every time; done width always 1.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one step per clock.
// Optional macro BCD_DIGIT_CHECK_EN rejects inputs with any nibble above 9 (err=1, no conversion).
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;

  // Shift right, then pull every BCD nibble that reached >=8 back down by 3 (no inter-nibble borrow).
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] s;
    s = sr >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[BIN_W + 4*i + 3]) begin
        s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4] - 4'd3;
      end else begin
        s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4];
      end
    end
    return s;
  endfunction

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
          if (has_bad_digit(bcd_in)) begin
            bin_d  = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            sr_d    = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            state_d = CONV;
            busy_d  = 1'b1;
          end
`else
          sr_d    = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          state_d = CONV;
          busy_d  = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        sr_d  = dabble_step(sr_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bin_d   = sr_d[BIN_W-1:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
`ifndef BCD_DIGIT_CHECK_EN
    err_d = 1'b0;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed scenarios plus random BCD against a decimal model.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = BIN_W + 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [15:0]       bcd_in;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  int tests;
  int fails;
  int overlap_cnt;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be seen together
  always @(negedge clk) begin
    if (busy && done) overlap_cnt++;
  end

  function automatic int bcd_value(input logic [15:0] b);
    int v;
    int w;
    v = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + int'(b[4*i +: 4]) * w;
      w = w * 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] b;
    for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'($urandom_range(9, 0));
    return b;
  endfunction

  // Launch one conversion and observe it; lat counts negedges after the accepting edge until done.
  task automatic do_conv(input logic [15:0] v, input bit noise,
                         output logic [BIN_W-1:0] res, output logic e,
                         output int lat, output int bcnt, output logic wide);
    bit seen;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (noise) bcd_in = 16'($urandom);
    lat  = 0;
    bcnt = 0;
    seen = 1'b0;
    res  = '0;
    e    = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1;
        res  = bin_out;
        e    = err;
      end else if (noise) begin
        start  = 1'($urandom_range(1, 0));
        bcd_in = 16'($urandom);
      end
    end
    start = 1'b0;
    if (!seen) lat = -1;
    @(negedge clk);
    wide = done;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 16'h0000;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, bin_out, err} !== {1'b0, 1'b0, 14'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b bin=%0d err=%b, want all 0", busy, done, bin_out, err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_known();
    logic [15:0] vecs [3];
    logic [BIN_W-1:0] res;
    logic e, wide;
    int lat, bcnt;
    vecs[0] = 16'h1234;
    vecs[1] = 16'h9999;
    vecs[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      do_conv(vecs[i], 1'b0, res, e, lat, bcnt, wide);
      tests++;
      if (res !== 14'(bcd_value(vecs[i])) || e !== 1'b0) begin
        fails++;
        $display("FAIL known_%h: bin=%0d err=%b, want %0d err=0", vecs[i], res, e, bcd_value(vecs[i]));
      end
      tests++;
      if (lat != LAT || bcnt != BIN_W) begin
        fails++;
        $display("FAIL known_lat_%h: lat=%0d busy=%0d, want %0d/%0d", vecs[i], lat, bcnt, LAT, BIN_W);
      end
      tests++;
      if (wide !== 1'b0) begin
        fails++;
        $display("FAIL known_width_%h: done still high, want 1-cycle pulse", vecs[i]);
      end
    end
    repeat (4) @(negedge clk);
    tests++;
    if (bin_out !== 14'd0) begin
      fails++;
      $display("FAIL hold: bin=%0d, want 0 held", bin_out);
    end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int last_done, n_done, nxt;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0001;
    exp_q.push_back(1);
    last_done = -1;
    n_done    = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) begin
        tests++;
        if (exp_q.size() == 0 || bin_out !== 14'(exp_q[0])) begin
          fails++;
          $display("FAIL b2b_value: bin=%0d, want %0d", bin_out, (exp_q.size() != 0) ? exp_q[0] : -1);
        end
        nxt = (exp_q.size() != 0 && exp_q[0] == 1) ? 100 : 1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (last_done >= 0) begin
          tests++;
          if (c - last_done != LAT) begin
            fails++;
            $display("FAIL b2b_period: %0d cycles, want %0d", c - last_done, LAT);
          end
        end
        last_done = c;
        n_done++;
        bcd_in = (nxt == 1) ? 16'h0001 : 16'h0100;
        exp_q.push_back(nxt);
      end else if (busy) begin
        bcd_in = 16'($urandom);
      end
    end
    start = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    tests++;
    if (n_done < 5) begin
      fails++;
      $display("FAIL b2b_count: %0d done pulses, want >=5", n_done);
    end
  endtask

  task automatic test_digit_check();
    logic [BIN_W-1:0] res;
    logic e, wide;
    int lat, bcnt;
    do_conv(16'h12A4, 1'b0, res, e, lat, bcnt, wide);
`ifdef BCD_DIGIT_CHECK_EN
    tests++;
    if (res !== 14'd0 || e !== 1'b1 || lat != 1 || bcnt != 0) begin
      fails++;
      $display("FAIL bad_digit: bin=%0d err=%b lat=%0d busy=%0d, want 0/1/1/0", res, e, lat, bcnt);
    end
`else
    tests++;
    if (e !== 1'b0 || lat != LAT) begin
      fails++;
      $display("FAIL bad_digit_nocheck: err=%b lat=%0d, want 0/%0d", e, lat, LAT);
    end
`endif
    do_conv(16'h0042, 1'b0, res, e, lat, bcnt, wide);
    tests++;
    if (res !== 14'd42 || e !== 1'b0 || lat != LAT) begin
      fails++;
      $display("FAIL after_bad: bin=%0d err=%b lat=%0d, want 42/0/%0d", res, e, lat, LAT);
    end
  endtask

  task automatic test_reset_mid();
    logic [BIN_W-1:0] res;
    logic e, wide;
    int lat, bcnt, n_done;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, bin_out, err} !== {1'b0, 1'b0, 14'd0, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset: busy=%b done=%b bin=%0d err=%b, want all 0", busy, done, bin_out, err);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    tests++;
    if (n_done != 0) begin
      fails++;
      $display("FAIL mid_reset_nodone: %0d busy/done cycles, want 0", n_done);
    end
    do_conv(16'h0007, 1'b0, res, e, lat, bcnt, wide);
    tests++;
    if (res !== 14'd7 || e !== 1'b0 || lat != LAT) begin
      fails++;
      $display("FAIL after_reset: bin=%0d err=%b lat=%0d, want 7/0/%0d", res, e, lat, LAT);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [BIN_W-1:0] res;
    logic e, wide;
    int lat, bcnt, bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      v = rand_bcd();
      do_conv(v, 1'b1, res, e, lat, bcnt, wide);
      tests++;
      if (res !== 14'(bcd_value(v)) || e !== 1'b0 || lat != LAT || wide !== 1'b0) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%h: bin=%0d err=%b lat=%0d wide=%b, want %0d/0/%0d/0",
                   v, res, e, lat, wide, bcd_value(v), LAT);
      end
    end
  endtask

  task automatic test_overlap();
    tests++;
    if (overlap_cnt != 0) begin
      fails++;
      $display("FAIL busy_done_overlap: %0d cycles, want 0", overlap_cnt);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    overlap_cnt = 0;
    test_reset();
    test_known();
    test_back_to_back();
    test_digit_check();
    test_reset_mid();
    test_random();
    test_overlap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
